soc_tick_capture_wb: RTL and testbench

- Wishbone peripheral on one slot of the SoC external master bus (`wb_m_*`). Consumes the `tick_e1` and `tick_usb_sof` strobes that the SoC exports.
- Counts every E1 monitor tick per source and runs a free-running system-time counter.
- On each USB SOF, atomically snapshots all counters so firmware can correlate E1 line rate against USB frame timing (rate matching / clock recovery).

---
 rtl/soc_tick_capture_wb.sv | 193 +++++++++++++++++++
 tb/tb_soc_tick_capture_wb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_tick_capture_wb.sv
// -----------------------------------------------------------------------------
// soc_tick_capture_wb
//
// Wishbone peripheral that counts E1 monitor tick strobes per source, runs a
// free-running 32-bit system-time counter and, on every USB start-of-frame,
// snapshots all counters so firmware can correlate E1 line rate with USB frame
// timing.
//
// Ports:
//   clk           system clock (clk_sys domain)
//   rst_n         synchronous active-low reset
//   wb_addr       word address (4 bits)
//   wb_rdata      registered read data, non-zero only while wb_ack is high
//   wb_wdata      write data
//   wb_we         write enable
//   wb_cyc        cycle/strobe
//   wb_ack        registered acknowledge, one wait state per access
//   tick_e1       per-source tick strobes, bit 4*k+j = unit k, source j
//   tick_usb_sof  USB start-of-frame strobe (already in clk domain)
//   irq           mirrors CSR.valid
//
// Register map (read):
//   0      CSR {ovr, valid}, write-1-to-clear, SOF wins over a same-cycle clear
//   1      live time counter (writable)
//   2      time counter snapshot
//   3      {16'h0, SOF counter}
//   8+2k   {snap_e[k][1], snap_e[k][0]}
//   9+2k   {snap_e[k][3], snap_e[k][2]}
//   others and units k >= E1_N read 0
// -----------------------------------------------------------------------------
module soc_tick_capture_wb #(
    parameter int E1_N = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          wb_addr,
    output logic [31:0]         wb_rdata,
    input  logic [31:0]         wb_wdata,
    input  logic                wb_we,
    input  logic                wb_cyc,
    output logic                wb_ack,
    input  logic [4*E1_N-1:0]   tick_e1,
    input  logic                tick_usb_sof,
    output logic                irq
);

    localparam int NSRC = 4 * E1_N;

    logic        ack_r;
    logic [31:0] rdata_r;
    logic [31:0] tcnt_r;
    logic [31:0] snap_t_r;
    logic [15:0] scnt_r;
    logic        valid_r;
    logic        ovr_r;

    logic        rd_take_s;
    logic        wr_beat_s;
    logic        wr_csr_s;
    logic        wr_tcnt_s;
    logic        clr_valid_s;
    logic        clr_ovr_s;
    logic [31:0] rd_mux_s;

    // Snapshot slots for the maximum of four units; slots beyond E1_N are tied
    // to zero so the read mux needs no range check.
    logic [15:0] snap_pad_s [16];

    // Read data is captured on the first cycle of an access; writes act in the
    // ack cycle, when the master is still holding the beat.
    assign rd_take_s   = wb_cyc & ~ack_r;
    assign wr_beat_s   = ack_r & wb_cyc & wb_we;
    assign wr_csr_s    = wr_beat_s & (wb_addr == 4'd0);
    assign wr_tcnt_s   = wr_beat_s & (wb_addr == 4'd1);
    assign clr_valid_s = wr_csr_s & wb_wdata[0];
    assign clr_ovr_s   = wr_csr_s & wb_wdata[1];

    assign wb_ack   = ack_r;
    assign wb_rdata = rdata_r;
    assign irq      = valid_r;

    for (genvar i = 0; i < 16; i++) begin : g_slot
        if (i < NSRC) begin : g_src
            logic [15:0] ecnt_r;
            logic [15:0] snap_r;
            logic [15:0] ecnt_nxt_s;

            // The snapshot takes the post-update count so a coincident tick counts.
            assign ecnt_nxt_s = ecnt_r + {15'd0, tick_e1[i]};

            // Per-source tick counter and its SOF snapshot.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ecnt_r <= 16'd0;
                    snap_r <= 16'd0;
                end else begin
                    ecnt_r <= ecnt_nxt_s;
                    if (tick_usb_sof) begin
                        snap_r <= ecnt_nxt_s;
                    end else begin
                        snap_r <= snap_r;
                    end
                end
            end

            assign snap_pad_s[i] = snap_r;
        end else begin : g_unused
            assign snap_pad_s[i] = 16'd0;
        end
    end

    // Read-data mux over the register map.
    always_comb begin
        rd_mux_s = 32'd0;
        if (wb_addr[3]) begin
            // addr 8+2k+h selects sources 4k+2h (low half) and 4k+2h+1 (high half)
            rd_mux_s = {snap_pad_s[{wb_addr[2:0], 1'b1}], snap_pad_s[{wb_addr[2:0], 1'b0}]};
        end else begin
            case (wb_addr[2:0])
                3'd0:    rd_mux_s = {30'd0, ovr_r, valid_r};
                3'd1:    rd_mux_s = tcnt_r;
                3'd2:    rd_mux_s = snap_t_r;
                3'd3:    rd_mux_s = {16'd0, scnt_r};
                default: rd_mux_s = 32'd0;
            endcase
        end
    end

    // Wishbone acknowledge and read-data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            ack_r <= wb_cyc & ~ack_r;
            if (rd_take_s) begin
                rdata_r <= rd_mux_s;
            end else begin
                rdata_r <= 32'd0;
            end
        end
    end

    // Free-running time counter with firmware load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt_r <= 32'd0;
        end else if (wr_tcnt_s) begin
            tcnt_r <= wb_wdata;
        end else begin
            tcnt_r <= tcnt_r + 32'd1;
        end
    end

    // SOF counter and time snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scnt_r   <= 16'd0;
            snap_t_r <= 32'd0;
        end else if (tick_usb_sof) begin
            scnt_r   <= scnt_r + 16'd1;
            snap_t_r <= tcnt_r;
        end else begin
            scnt_r   <= scnt_r;
            snap_t_r <= snap_t_r;
        end
    end

    // CSR valid/ovr flags; a SOF overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            if (tick_usb_sof) begin
                valid_r <= 1'b1;
            end else if (clr_valid_s) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end

            if (tick_usb_sof && valid_r) begin
                ovr_r <= 1'b1;
            end else if (clr_ovr_s) begin
                ovr_r <= 1'b0;
            end else begin
                ovr_r <= ovr_r;
            end
        end
    end

endmodule

// File: tb/tb_soc_tick_capture_wb.sv
// -----------------------------------------------------------------------------
// tb_soc_tick_capture_wb
//
// Self-checking bench for soc_tick_capture_wb with E1_N = 2. A behavioural
// model (integer counters, modulo arithmetic) tracks the expected register
// contents, ack and read data every cycle; directed sequences add fixed
// expected values for reset, tick counting, SOF coincidence, wrap, bus
// protocol and overrun clearing, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_soc_tick_capture_wb;

    localparam int E1_N = 2;
    localparam int NSRC = 4 * E1_N;

    logic            clk;
    logic            rst_n;
    logic [3:0]      wb_addr;
    logic [31:0]     wb_rdata;
    logic [31:0]     wb_wdata;
    logic            wb_we;
    logic            wb_cyc;
    logic            wb_ack;
    logic [NSRC-1:0] tick_e1;
    logic            tick_usb_sof;
    logic            irq;

    soc_tick_capture_wb #(.E1_N(E1_N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_addr      (wb_addr),
        .wb_rdata     (wb_rdata),
        .wb_wdata     (wb_wdata),
        .wb_we        (wb_we),
        .wb_cyc       (wb_cyc),
        .wb_ack       (wb_ack),
        .tick_e1      (tick_e1),
        .tick_usb_sof (tick_usb_sof),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit rnd_mode = 1'b0;

    // reference model state
    bit [31:0] m_tcnt;
    bit [31:0] m_snap_t;
    bit [31:0] m_rdata;
    int        m_ecnt   [NSRC];
    int        m_snap_e [NSRC];
    int        m_scnt;
    bit        m_valid;
    bit        m_ovr;
    bit        m_ack;

    logic [31:0] rd;
    int          rst_addrs [9] = '{0, 2, 3, 8, 9, 10, 11, 12, 15};

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [31:0] model_read(input int a);
        int k;
        int h;
        if (a == 0) return {30'd0, m_ovr, m_valid};
        if (a == 1) return m_tcnt;
        if (a == 2) return m_snap_t;
        if (a == 3) return 32'(m_scnt);
        if (a >= 8) begin
            k = (a - 8) / 2;
            h = (a - 8) % 2;
            if (k < E1_N) begin
                return (32'(m_snap_e[4*k + 2*h + 1]) << 16) | 32'(m_snap_e[4*k + 2*h]);
            end
        end
        return 32'd0;
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_clock();
        bit [31:0] rdv;
        bit        wr;
        bit        sof;
        bit        v_old;
        int        a;
        if (!rst_n) begin
            m_tcnt = 32'd0; m_snap_t = 32'd0; m_rdata = 32'd0;
            m_scnt = 0; m_valid = 1'b0; m_ovr = 1'b0; m_ack = 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                m_ecnt[i] = 0;
                m_snap_e[i] = 0;
            end
            return;
        end
        a   = int'(wb_addr);
        sof = tick_usb_sof;
        rdv = (wb_cyc && !m_ack) ? model_read(a) : 32'd0;
        wr  = m_ack && wb_cyc && wb_we;
        if (sof) m_snap_t = m_tcnt;
        m_tcnt = (wr && a == 1) ? wb_wdata : m_tcnt + 32'd1;
        for (int i = 0; i < NSRC; i++) begin
            m_ecnt[i] = (m_ecnt[i] + int'((tick_e1 >> i) & NSRC'(1))) % 65536;
            if (sof) m_snap_e[i] = m_ecnt[i];
        end
        if (sof) m_scnt = (m_scnt + 1) % 65536;
        v_old = m_valid;
        if (wr && a == 0 && wb_wdata[0]) m_valid = 1'b0;
        if (wr && a == 0 && wb_wdata[1]) m_ovr = 1'b0;
        if (sof) begin
            if (v_old) m_ovr = 1'b1;
            m_valid = 1'b1;
        end
        m_ack   = wb_cyc && !m_ack;
        m_rdata = rdv;
    endtask

    // One clock: optional random ticks, model update, compare at falling edge.
    task automatic cyc1();
        if (rnd_mode) begin
            tick_e1      = NSRC'($urandom);
            tick_usb_sof = ($urandom_range(0, 5) == 0);
        end
        @(posedge clk);
        model_clock();
        @(negedge clk);
        chk_eq("ack", {31'd0, wb_ack}, {31'd0, m_ack});
        chk_eq("rdata", wb_rdata, m_rdata);
        chk_eq("irq", {31'd0, irq}, {31'd0, m_valid});
    endtask

    // Single Wishbone access; cyc is held through the ack edge.
    task automatic bus_xfer(input logic we, input logic [3:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        wb_cyc   = 1'b1;
        wb_we    = we;
        wb_addr  = addr;
        wb_wdata = wdata;
        cyc1();
        rdata = wb_rdata;
        cyc1();
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic sof_pulse();
        tick_usb_sof = 1'b1;
        cyc1();
        tick_usb_sof = 1'b0;
        cyc1();
    endtask

    initial begin
        rst_n = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; wb_addr = 4'd0; wb_wdata = 32'd0;
        tick_e1 = '0; tick_usb_sof = 1'b0;
        @(negedge clk);

        // reset held with random tick activity
        rnd_mode = 1'b1;
        repeat (3) cyc1();
        rnd_mode = 1'b0;
        tick_e1 = '0; tick_usb_sof = 1'b0; rst_n = 1'b1;
        cyc1();
        chk_eq("rst_ack", {31'd0, wb_ack}, 32'd0);
        chk_eq("rst_irq", {31'd0, irq}, 32'd0);
        foreach (rst_addrs[i]) begin
            bus_xfer(1'b0, 4'(rst_addrs[i]), 32'd0, rd);
            chk_eq("rst_read", rd, 32'd0);
        end

        // tick counting on unit 1 source 1
        repeat (7) begin
            tick_e1 = 8'h20; cyc1();
            tick_e1 = 8'h00; cyc1();
        end
        sof_pulse();
        bus_xfer(1'b0, 4'd10, 32'd0, rd); chk_eq("tick_addr10", rd, 32'h0007_0000);
        bus_xfer(1'b0, 4'd3,  32'd0, rd); chk_eq("tick_scnt", rd, 32'd1);
        bus_xfer(1'b0, 4'd0,  32'd0, rd); chk_eq("tick_csr", rd, 32'd1);
        chk_eq("tick_irq", {31'd0, irq}, 32'd1);

        // coincident tick and SOF, then W1C racing a SOF
        bus_xfer(1'b1, 4'd0, 32'd3, rd);
        bus_xfer(1'b0, 4'd0, 32'd0, rd); chk_eq("clr_csr", rd, 32'd0);
        repeat (2) begin
            tick_e1 = 8'h01; cyc1();
            tick_e1 = 8'h00; cyc1();
        end
        tick_e1 = 8'h01; tick_usb_sof = 1'b1; cyc1();
        tick_e1 = 8'h00; tick_usb_sof = 1'b0; cyc1();
        bus_xfer(1'b0, 4'd8, 32'd0, rd); chk_eq("coinc_lo", rd & 32'h0000_FFFF, 32'd3);
        wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = 4'd0; wb_wdata = 32'd1;
        cyc1();
        tick_usb_sof = 1'b1;
        cyc1();
        tick_usb_sof = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        bus_xfer(1'b0, 4'd0, 32'd0, rd); chk_eq("sof_wins", rd, 32'd3);

        // 16-bit tick counter wrap
        tick_e1 = 8'h08;
        repeat (65537) cyc1();
        tick_e1 = 8'h00;
        sof_pulse();
        bus_xfer(1'b0, 4'd9, 32'd0, rd); chk_eq("wrap_addr9", rd, 32'h0001_0000);

        // time counter load and wrap
        bus_xfer(1'b1, 4'd1, 32'hFFFF_FFFE, rd);
        repeat (3) cyc1();
        sof_pulse();
        bus_xfer(1'b0, 4'd2, 32'd0, rd);
        chk_eq("snap_t_small", {31'd0, (rd <= 32'd3)}, 32'd1);
        chk_eq("snap_t_exact", rd, 32'd1);

        // bus protocol with cyc held continuously
        wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 4'd0;
        chk_eq("hold_ack0", {31'd0, wb_ack}, 32'd0);
        cyc1(); chk_eq("hold_ack1", {31'd0, wb_ack}, 32'd1);
        cyc1(); chk_eq("hold_ack2", {31'd0, wb_ack}, 32'd0);
        chk_eq("hold_rdata0", wb_rdata, 32'd0);
        cyc1(); chk_eq("hold_ack3", {31'd0, wb_ack}, 32'd1);
        cyc1();
        wb_cyc = 1'b0;
        bus_xfer(1'b0, 4'd5,  32'd0, rd); chk_eq("unused_addr5", rd, 32'd0);
        bus_xfer(1'b0, 4'd12, 32'd0, rd); chk_eq("absent_unit", rd, 32'd0);
        bus_xfer(1'b1, 4'd2, 32'hDEAD_BEEF, rd);
        bus_xfer(1'b0, 4'd2, 32'd0, rd); chk_eq("ro_snap_t", rd, 32'd1);
        bus_xfer(1'b1, 4'd3, 32'h0000_1234, rd);
        bus_xfer(1'b0, 4'd3, 32'd0, rd); chk_eq("ro_scnt", rd, 32'd5);

        // overrun set and clear
        bus_xfer(1'b1, 4'd0, 32'd3, rd);
        sof_pulse();
        sof_pulse();
        bus_xfer(1'b0, 4'd0, 32'd0, rd); chk_eq("ovr_set", rd, 32'd3);
        bus_xfer(1'b1, 4'd0, 32'd2, rd);
        bus_xfer(1'b0, 4'd0, 32'd0, rd); chk_eq("ovr_clr", rd, 32'd1);
        bus_xfer(1'b1, 4'd0, 32'd1, rd);
        bus_xfer(1'b0, 4'd0, 32'd0, rd); chk_eq("valid_clr", rd, 32'd0);
        chk_eq("irq_clr", {31'd0, irq}, 32'd0);

        // reset in the middle of a bus cycle drops ack
        wb_cyc = 1'b1; wb_addr = 4'd1;
        cyc1();
        rst_n = 1'b0;
        cyc1();
        chk_eq("midrst_ack", {31'd0, wb_ack}, 32'd0);
        rst_n = 1'b1; wb_cyc = 1'b0;
        cyc1();

        // randomized traffic against the model
        rnd_mode = 1'b1;
        repeat (400) begin
            case ($urandom_range(0, 4))
                0:       cyc1();
                1:       bus_xfer(1'b0, 4'($urandom_range(0, 15)), 32'd0, rd);
                2:       bus_xfer(1'b1, 4'd0, $urandom, rd);
                3:       bus_xfer(1'b1, 4'd1, $urandom, rd);
                default: bus_xfer(1'b1, 4'($urandom_range(0, 15)), $urandom, rd);
            endcase
        end
        rnd_mode = 1'b0;
        tick_e1 = '0; tick_usb_sof = 1'b0;
        for (int a = 0; a < 16; a++) begin
            bus_xfer(1'b0, 4'(a), 32'd0, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
